frame_config_writer: RTL

Configuration-side driver for the fabric's frame configuration interface. It consumes a stream of 32-bit bitstream words, assembles one configuration frame across all fabric rows into a FrameData register, and then fires a single one-hot FrameStrobe pulse that latches the frame into the addressed column's ConfigMem instances. It sits between the bitstream source (UART/SPI loader) and the fabric's FrameData/FrameStrobe inputs.

---
 rtl/frame_writer_pkg.sv | 15 +
 rtl/frame_strobe_decoder.sv | 35 +++
 rtl/frame_config_writer.sv | 113 +++++++++++
 3 files changed

// File: rtl/frame_writer_pkg.sv
// rtl/frame_writer_pkg.sv - shared types and header field layout for the frame configuration writer
package frame_writer_pkg;

  typedef enum logic [1:0] {IDLE, DATA, STROBE, HOLD} state_t;

  localparam logic [3:0] OPC_WRITE_FRAME = 4'hA;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int COL_MSB = 23;
  localparam int COL_LSB = 16;
  localparam int FRM_MSB = 15;
  localparam int FRM_LSB = 8;

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - registered one-hot decode of (column, frame, enable) onto FrameStrobe
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 16
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [7:0]                            column,
  input  logic [7:0]                            frame,
  input  logic                                  enable,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  logic [NumColumns*MaxFramesPerCol-1:0] strobe_n;

  always_comb begin
    strobe_n = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        if (enable && column == 8'(c) && frame == 8'(f)) begin
          strobe_n[c*MaxFramesPerCol+f] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      strobe <= '0;
    end else begin
      strobe <= strobe_n;
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// rtl/frame_config_writer.sv - assembles one frame from bitstream words and fires its FrameStrobe pulse
// Optional frames_written counter enabled by FRAME_WRITER_CNT_EN.
module frame_config_writer
  import frame_writer_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 16,
  parameter int NumColumns      = 16
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [31:0]                           word_data,
  input  logic                                  word_valid,
  output logic                                  word_ready,
  input  logic                                  err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  frame_done,
`ifdef FRAME_WRITER_CNT_EN
  output logic [15:0]                           frames_written,
`endif
  output logic                                  error
);

  localparam int RowW = $clog2(NumRows);
  localparam logic [7:0] COL_LIM = 8'(NumColumns);
  localparam logic [7:0] FRM_LIM = 8'(MaxFramesPerCol);

  state_t         state;
  logic [RowW-1:0] row_cnt;
  logic [7:0]     col_q;
  logic [7:0]     frm_q;
  logic           take;
  logic           hdr_ok;
  logic           last_row;
  logic           unused_hdr_bits;

  assign word_ready = (state == IDLE) || (state == DATA);
  assign take       = word_valid && word_ready;
  assign hdr_ok     = (word_data[OPC_MSB:OPC_LSB] == OPC_WRITE_FRAME) &&
                      (word_data[COL_MSB:COL_LSB] < COL_LIM) &&
                      (word_data[FRM_MSB:FRM_LSB] < FRM_LIM);
  assign last_row   = (row_cnt == RowW'(NumRows - 1));
  assign unused_hdr_bits = ^{word_data[27:24], word_data[7:0]};

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      row_cnt    <= '0;
      col_q      <= '0;
      frm_q      <= '0;
      FrameData  <= '0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      frame_done <= (state == STROBE);
      case (state)
        IDLE: begin
          if (take && hdr_ok) begin
            col_q   <= word_data[COL_MSB:COL_LSB];
            frm_q   <= word_data[FRM_MSB:FRM_LSB];
            row_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (take) begin
            FrameData[int'(row_cnt)*FrameBitsPerRow +: FrameBitsPerRow] <= word_data;
            // Counter parks on the last row rather than wrapping.
            if (last_row) begin
              state <= STROBE;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        STROBE:  state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A rejected header in the same cycle as err_clr keeps the flag set.
      if (state == IDLE && take && !hdr_ok) begin
        error <= 1'b1;
      end else if (err_clr) begin
        error <= 1'b0;
      end
    end
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .NumColumns     (NumColumns)
  ) u_strobe (
    .CLK   (CLK),
    .reset (reset),
    .column(col_q),
    .frame (frm_q),
    .enable(state == DATA && take && last_row),
    .strobe(FrameStrobe)
  );

`ifdef FRAME_WRITER_CNT_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      frames_written <= '0;
    end else if (state == HOLD) begin
      frames_written <= frames_written + 16'd1;
    end
  end
`endif

endmodule
